// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and rise-to-rise period of pwm_in in clk cycles,
// publishing each completed period with a one-cycle valid strobe and flagging a stuck input.
module pwm_capture #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] high_count,
    output logic [CNT_WIDTH-1:0] period_count,
    output logic                 valid,
    output logic                 stuck_high,
    output logic                 stuck_low
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 s1;
    logic                 s2;
    logic                 s_prev;
    logic                 rise;
    logic [CNT_WIDTH-1:0] per_cnt;
    logic [CNT_WIDTH-1:0] hi_cnt;
    logic                 publish;
    logic                 restart;
    logic                 timeout;
    logic                 count_en;
    logic                 flag_clr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            s1     <= pwm_in;
            s2     <= s1;
            s_prev <= s2;
        end
    end

    assign rise = s2 & ~s_prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ARM;
                ARM:     if (rise) state_nxt = MEASURE;
                MEASURE: if (timeout) state_nxt = ARM;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A rise in the timeout cycle wins, so timeout is only raised when rise is low.
    always_comb begin
        publish  = 1'b0;
        restart  = 1'b0;
        timeout  = 1'b0;
        count_en = 1'b0;
        flag_clr = 1'b0;
        if (!enable) begin
            flag_clr = 1'b1;
        end else begin
            case (state)
                ARM: begin
                    restart = rise;
                end
                MEASURE: begin
                    if (rise) begin
                        publish  = 1'b1;
                        restart  = 1'b1;
                        flag_clr = 1'b1;
                    end else if (per_cnt == CNT_MAX) begin
                        timeout = 1'b1;
                    end else begin
                        count_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // per_cnt never reaches count_en at CNT_MAX, so only hi_cnt needs its own saturation guard.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (restart) begin
            per_cnt <= CNT_ONE;
            hi_cnt  <= CNT_ONE;
        end else if (count_en) begin
            per_cnt <= per_cnt + CNT_ONE;
            if (s2 && (hi_cnt != CNT_MAX)) begin
                hi_cnt <= hi_cnt + CNT_ONE;
            end
        end else begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            high_count   <= '0;
            period_count <= '0;
            valid        <= 1'b0;
            stuck_high   <= 1'b0;
            stuck_low    <= 1'b0;
        end else begin
            valid <= publish;
            if (publish) begin
                high_count   <= hi_cnt;
                period_count <= per_cnt;
            end
            if (flag_clr) begin
                stuck_high <= 1'b0;
                stuck_low  <= 1'b0;
            end else if (timeout) begin
                stuck_high <= s2;
                stuck_low  <= ~s2;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture: a timestamp-based reference model predicts every output
// each cycle from the sampled input history, plus directed scenarios with fixed expectations.
module tb_pwm_capture;

    localparam int unsigned W    = 8;
    localparam int          MAXE = 40000;
    localparam int          TMO  = 255;

    logic         clk;
    logic         reset_n;
    logic         enable;
    logic         pwm_in;
    logic [W-1:0] high_count;
    logic [W-1:0] period_count;
    logic         valid;
    logic         stuck_high;
    logic         stuck_low;

    int checks = 0;
    int errors = 0;

    pwm_capture #(.CNT_WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .pwm_in       (pwm_in),
        .high_count   (high_count),
        .period_count (period_count),
        .valid        (valid),
        .stuck_high   (stuck_high),
        .stuck_low    (stuck_low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: raw[] holds pwm_in as seen at each clock edge; the synchronized level
    // at edge n is the sample from edge n-2, with everything up to a reset edge reading as 0.
    typedef enum {M_IDLE, M_ARM, M_MEAS} mmode_t;

    bit     raw [MAXE];
    int     n          = 0;
    int     reset_edge = -1;
    bit     seen_reset = 1'b0;
    mmode_t m_mode     = M_IDLE;
    int     last_rise  = 0;
    int     m_hc       = 0;
    int     m_pc       = 0;
    bit     m_valid    = 1'b0;
    bit     m_sh       = 1'b0;
    bit     m_sl       = 1'b0;

    function automatic bit sync_lvl(input int k);
        return (k >= 0 && k > reset_edge) ? raw[k] : 1'b0;
    endfunction

    always @(posedge clk) begin
        bit lvl;
        bit rise_now;
        int hsum;
        if (n < MAXE) raw[n] = pwm_in;
        if (!reset_n) begin
            reset_edge = n;
            seen_reset = 1'b1;
            m_mode     = M_IDLE;
            m_hc       = 0;
            m_pc       = 0;
            m_valid    = 1'b0;
            m_sh       = 1'b0;
            m_sl       = 1'b0;
        end else if (seen_reset) begin
            lvl      = sync_lvl(n - 2);
            rise_now = lvl && !sync_lvl(n - 3);
            m_valid  = 1'b0;
            if (!enable) begin
                m_mode = M_IDLE;
                m_sh   = 1'b0;
                m_sl   = 1'b0;
            end else begin
                case (m_mode)
                    M_IDLE: m_mode = M_ARM;
                    M_ARM: begin
                        if (rise_now) begin
                            m_mode    = M_MEAS;
                            last_rise = n;
                        end
                    end
                    M_MEAS: begin
                        if (rise_now) begin
                            hsum = 0;
                            for (int m = last_rise; m < n; m++) hsum += int'(sync_lvl(m - 2));
                            m_pc      = n - last_rise;
                            m_hc      = hsum;
                            m_valid   = 1'b1;
                            m_sh      = 1'b0;
                            m_sl      = 1'b0;
                            last_rise = n;
                        end else if (n - last_rise == TMO) begin
                            m_sh   = lvl;
                            m_sl   = !lvl;
                            m_mode = M_ARM;
                        end
                    end
                    default: m_mode = M_IDLE;
                endcase
            end
        end
        n++;
        if (seen_reset) begin
            #1;
            check("valid", 32'(valid), 32'(m_valid));
            check("high_count", 32'(high_count), 32'(m_hc));
            check("period_count", 32'(period_count), 32'(m_pc));
            check("stuck_high", 32'(stuck_high), 32'(m_sh));
            check("stuck_low", 32'(stuck_low), 32'(m_sl));
        end
    end

    task automatic wave(input int unsigned h, input int unsigned l, input int unsigned nper);
        for (int unsigned p = 0; p < nper; p++) begin
            pwm_in = 1'b1;
            repeat (h) @(negedge clk);
            pwm_in = 1'b0;
            repeat (l) @(negedge clk);
        end
    endtask

    task automatic hold(input bit lvl, input int unsigned cycles);
        pwm_in = lvl;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        pwm_in  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(valid), 0);
        check("rst_hc", 32'(high_count), 0);
        check("rst_pc", 32'(period_count), 0);
        check("rst_sh", 32'(stuck_high), 0);
        check("rst_sl", 32'(stuck_low), 0);

        enable = 1'b1;
        repeat (4) @(negedge clk);

        wave(30, 70, 5);
        check("d30_hc", 32'(high_count), 30);
        check("d30_pc", 32'(period_count), 100);

        wave(2, 2, 6);
        check("min_hc", 32'(high_count), 2);
        check("min_pc", 32'(period_count), 4);

        wave(10, 90, 3);
        wave(60, 40, 3);
        check("chg_hc", 32'(high_count), 60);
        check("chg_pc", 32'(period_count), 100);

        hold(1'b0, 300);
        check("lo_sl", 32'(stuck_low), 1);
        check("lo_sh", 32'(stuck_high), 0);
        check("lo_hc_hold", 32'(high_count), 60);
        check("lo_pc_hold", 32'(period_count), 100);

        wave(5, 300, 1);
        check("lo2_sl", 32'(stuck_low), 1);
        wave(5, 5, 4);
        check("rec_hc", 32'(high_count), 5);
        check("rec_pc", 32'(period_count), 10);
        check("rec_sl", 32'(stuck_low), 0);

        hold(1'b1, 300);
        check("hi_sh", 32'(stuck_high), 1);
        check("hi_sl", 32'(stuck_low), 0);
        hold(1'b0, 10);

        wave(30, 70, 3);
        check("rearm_sh", 32'(stuck_high), 0);
        check("rearm_hc", 32'(high_count), 30);
        check("rearm_pc", 32'(period_count), 100);

        hold(1'b1, 15);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_hc", 32'(high_count), 0);
        check("mid_rst_pc", 32'(period_count), 0);
        hold(1'b1, 14);
        hold(1'b0, 70);
        wave(30, 70, 3);
        check("post_rst_hc", 32'(high_count), 30);
        check("post_rst_pc", 32'(period_count), 100);

        // Rise is seen by the capture logic two edges after pwm_in is first sampled high.
        pwm_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        check("en_drop_valid", 32'(valid), 0);
        hold(1'b1, 27);
        hold(1'b0, 70);
        check("en_drop_hc", 32'(high_count), 30);
        check("en_drop_pc", 32'(period_count), 100);
        wave(30, 70, 3);
        check("en_after_hc", 32'(high_count), 30);
        check("en_after_pc", 32'(period_count), 100);

        for (int i = 0; i < 40; i++) begin
            int unsigned k;
            k = $urandom_range(0, 9);
            if (k < 6) begin
                wave($urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(1, 4));
            end else if (k == 6) begin
                hold(1'($urandom_range(0, 1)), $urandom_range(250, 300));
            end else if (k == 7) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                enable = 1'b1;
            end else if (k == 8) begin
                reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end else begin
                wave(1, $urandom_range(1, 5), 3);
            end
        end
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
